event_stream_tx: RTL

// - Consumer end of the spike processing unit's event output: packetises classified events for off-chip transmission.
// - Captures each new nonzero code on event_in, timestamps it with a free-running sample counter, and attaches the count of spike_in pulses since the previous capture.
// - Buffers records in a FIFO and serialises each as a 7-byte framed packet over an 8-bit valid/ready stream.
// - Sits after the processing unit's classifier and spike detector, and ahead of the UART/USB bridge.
//

---
 rtl/event_stream_pkg.sv | 18 +
 rtl/event_fifo.sv | 52 +++++
 rtl/event_stream.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/event_stream_pkg.sv
// Shared types and constants for the event stream transmitter.
package event_stream_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         PKT_LEN   = 7;

   typedef struct packed {
      logic [23:0] ts;
      logic [7:0]  ev;
      logic [7:0]  spk;
   } evt_rec_t;

   typedef enum logic {
      IDLE,
      SEND
   } tx_state_t;

endpackage

// File: rtl/event_fifo.sv
// Single-clock synchronous FIFO; pointers carry an extra wrap bit so
// full and empty can be told apart without a separate counter.
module event_fifo
   import event_stream_pkg::*;
#(
   parameter int WIDTH = 40,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   // Advance the read and write pointers on accepted push/pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage array; contents need no reset since the pointers gate reads.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/event_stream.sv
// Event stream transmitter: captures classifier events with a timestamp and
// spike count, buffers them, and sends each as a 7-byte framed packet.
module event_stream_tx
   import event_stream_pkg::*;
#(
   parameter int TS_WIDTH    = 24,
   parameter int FIFO_DEPTH  = 16,
   parameter int EVENT_WIDTH = 32,
   parameter int OVF_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [EVENT_WIDTH-1:0]        event_in,
   input  logic                          spike_in,
   input  logic                          sample_en,
   output logic [7:0]                    tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [OVF_WIDTH-1:0]          overflow_cnt,
   output logic                          busy
);

   localparam logic [TS_WIDTH-1:0]  TS_ONE   = 1;
   localparam logic [OVF_WIDTH-1:0] OVF_ONE  = 1;
   localparam logic [2:0]           LAST_IDX = 3'(PKT_LEN - 1);

   logic [TS_WIDTH-1:0]    ts;
   logic [EVENT_WIDTH-1:0] prev_event;
   logic [7:0]             spk_cnt;
   logic [7:0]             spk_next;
   logic [7:0]             ev_byte;
   logic [7:0]             chk;
   logic                   capture;
   logic                   push_req;
   evt_rec_t               cap_rec;
   evt_rec_t               push_rec;
   evt_rec_t               pkt;
   evt_rec_t               fifo_dout;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   tx_state_t              state;
   tx_state_t              next_state;
   logic [2:0]             idx;
   logic [2:0]             next_idx;

   assign capture  = (event_in != '0) && (event_in != prev_event);
   assign ev_byte  = (|event_in[EVENT_WIDTH-1:8]) ? 8'hFF : event_in[7:0];
   assign spk_next = (spk_cnt == 8'hFF) ? 8'hFF : spk_cnt + {7'd0, spike_in};
   assign cap_rec  = '{ts: 24'(ts), ev: ev_byte, spk: spk_next};
   assign chk      = pkt.ts[23:16] ^ pkt.ts[15:8] ^ pkt.ts[7:0] ^ pkt.ev ^ pkt.spk;
   assign tx_valid = (state == SEND);
   assign busy     = (state == SEND) || !fifo_empty;

   // Timestamp, previous-event history and spike counter for event capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ts         <= '0;
         prev_event <= '0;
         spk_cnt    <= '0;
      end else begin
         prev_event <= event_in;
         spk_cnt    <= capture ? 8'd0 : spk_next;
         if (sample_en) ts <= ts + TS_ONE;
      end
   end

   // Register each captured record so it enters the FIFO one cycle later.
   always_ff @(posedge clk) begin
      if (!rst) begin
         push_req <= 1'b0;
         push_rec <= '0;
      end else begin
         push_req <= capture;
         if (capture) push_rec <= cap_rec;
      end
   end

   // Count records lost to a full FIFO, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow_cnt <= '0;
      end else if (push_req && fifo_full && (overflow_cnt != '1)) begin
         overflow_cnt <= overflow_cnt + OVF_ONE;
      end
   end

   event_fifo #(
      .WIDTH ($bits(evt_rec_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (fifo_pop),
      .din   (push_rec),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Transmit state, byte index and the packet being sent.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         idx   <= '0;
         pkt   <= '0;
      end else begin
         state <= next_state;
         idx   <= next_idx;
         if (fifo_pop) pkt <= fifo_dout;
      end
   end

   // Next-state logic: load a record when idle, step bytes on each handshake.
   always_comb begin
      next_state = state;
      next_idx   = idx;
      fifo_pop   = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               next_idx   = '0;
               next_state = SEND;
            end
         end
         SEND: begin
            if (tx_ready) begin
               if (idx == LAST_IDX) begin
                  next_idx   = '0;
                  next_state = IDLE;
               end else begin
                  next_idx = idx + 3'd1;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Select the outgoing byte for the current packet index.
   always_comb begin
      tx_data = 8'h00;
      if (state == SEND) begin
         case (idx)
            3'd0:    tx_data = SYNC_BYTE;
            3'd1:    tx_data = pkt.ts[23:16];
            3'd2:    tx_data = pkt.ts[15:8];
            3'd3:    tx_data = pkt.ts[7:0];
            3'd4:    tx_data = pkt.ev;
            3'd5:    tx_data = pkt.spk;
            3'd6:    tx_data = chk;
            default: tx_data = 8'h00;
         endcase
      end
   end

endmodule
